alu_port_arbiter: RTL and testbench



---
 rtl/alu_port_arbiter_pkg.sv | 14 +
 rtl/alu_port_arbiter_if.sv | 26 ++
 rtl/alu_port_arbiter_mux.sv | 15 +
 rtl/alu_port_arbiter.sv | 103 ++++++++++
 tb/tb_alu_port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_port_arbiter_pkg.sv
// Shared definitions for the ALU operand-port arbiter: state encoding,
// datapath width and the default hold limit.
package alu_port_arbiter_pkg;

  localparam int WORD_W           = 16;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/alu_port_arbiter_if.sv
// Requester/ALU-side bundle of the operand-port arbiter; the arbiter uses the
// slave view, the requester side (or a bench) uses the master view.
interface alu_port_arbiter_if;
  import alu_port_arbiter_pkg::*;

  logic              Req0;
  logic              Req1;
  logic [WORD_W-1:0] Data0;
  logic [WORD_W-1:0] Data1;
  logic              Gnt0;
  logic              Gnt1;
  logic              Sel;
  logic [WORD_W-1:0] OutData;
  logic              OutValid;

  modport master (
    output Req0, Req1, Data0, Data1,
    input  Gnt0, Gnt1, Sel, OutData, OutValid
  );

  modport slave (
    input  Req0, Req1, Data0, Data1,
    output Gnt0, Gnt1, Sel, OutData, OutValid
  );

endinterface

// File: rtl/alu_port_arbiter_mux.sv
// Plain two-input operand mux: SelectorBit=0 passes Zero, 1 passes One.
module alu_port_arbiter_mux
  import alu_port_arbiter_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] Zero,
  input  logic [W-1:0] One,
  input  logic         SelectorBit,
  output logic [W-1:0] Result
);

  assign Result = SelectorBit ? One : Zero;

endmodule

// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter for the shared ALU operand port, with a bounded hold
// time and a registered operand/valid output toward the ALU.
module alu_port_arbiter
  import alu_port_arbiter_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input logic              CLK,
  input logic              Reset_n,
  alu_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
  logic               lastGnt_q, lastGnt_d;
  logic [WIDTH-1:0]   outData_q, outData_d;
  logic               outValid_q, outValid_d;
  logic [WIDTH-1:0]   muxOut;
  logic               selBit;
  logic               transfer;
  logic               holdExpired;

  assign selBit    = (state_q == ST_OWN1);
  assign transfer  = ((state_q == ST_OWN0) && bus.Req0) ||
                     ((state_q == ST_OWN1) && bus.Req1);

  // A saturated counter still counts as expired, so a late-arriving
  // requester is never starved by an owner that has held the port long.
  assign holdExpired = (MAX_HOLD != 0) && (int'(holdCnt_q) >= MAX_HOLD - 1);

  alu_port_arbiter_mux #(.W(WIDTH)) u_mux (
    .Zero        (bus.Data0),
    .One         (bus.Data1),
    .SelectorBit (selBit),
    .Result      (muxOut)
  );

  always_comb begin
    state_d    = state_q;
    holdCnt_d  = '0;
    lastGnt_d  = lastGnt_q;
    outData_d  = transfer ? muxOut : outData_q;
    outValid_d = transfer;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Req0 && bus.Req1) state_d = lastGnt_q ? ST_OWN0 : ST_OWN1;
        else if (bus.Req0)        state_d = ST_OWN0;
        else if (bus.Req1)        state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!bus.Req0) begin
          lastGnt_d = 1'b0;
          state_d   = bus.Req1 ? ST_OWN1 : ST_IDLE;
        end else if (bus.Req1 && holdExpired) begin
          lastGnt_d = 1'b0;
          state_d   = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!bus.Req1) begin
          lastGnt_d = 1'b1;
          state_d   = bus.Req0 ? ST_OWN0 : ST_IDLE;
        end else if (bus.Req0 && holdExpired) begin
          lastGnt_d = 1'b1;
          state_d   = ST_OWN0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == state_q) && (state_q != ST_IDLE)) begin
      if (int'(holdCnt_q) < MAX_HOLD) holdCnt_d = holdCnt_q + CNT_W'(1);
      else                            holdCnt_d = holdCnt_q;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      holdCnt_q  <= '0;
      lastGnt_q  <= 1'b1;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      lastGnt_q  <= lastGnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.Gnt0     = (state_q == ST_OWN0);
  assign bus.Gnt1     = (state_q == ST_OWN1);
  assign bus.Sel      = selBit;
  assign bus.OutData  = outData_q;
  assign bus.OutValid = outValid_q;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: one instance with MAX_HOLD=8 and one with the
// limit disabled, both fed the same requests and checked against a model.
module tb_alu_port_arbiter;
  import alu_port_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] data0 = 16'h0;
  logic [15:0] data1 = 16'h0;

  alu_port_arbiter_if bus8 ();
  alu_port_arbiter_if bus0 ();

  assign bus8.Req0  = req0;
  assign bus8.Req1  = req1;
  assign bus8.Data0 = data0;
  assign bus8.Data1 = data1;
  assign bus0.Req0  = req0;
  assign bus0.Req1  = req1;
  assign bus0.Data0 = data0;
  assign bus0.Data1 = data1;

  alu_port_arbiter #(.WIDTH(16), .MAX_HOLD(8)) dut8 (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus8)
  );

  alu_port_arbiter #(.WIDTH(16), .MAX_HOLD(0)) dut0 (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus0)
  );

  always #5 CLK = ~CLK;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Model state per instance: owner -1 means nobody holds the port,
  // heldCycles counts completed cycles of the current ownership.
  int          mOwner[2];
  int          mHeld[2];
  int          mLast[2];
  int          mMax[2];
  logic [15:0] mData[2];
  logic        mValid[2];
  int          gnt0Seen[2];
  int          validSeen[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mOwner[k] = -1;
      mHeld[k]  = 0;
      mLast[k]  = 1;
      mData[k]  = 16'h0;
      mValid[k] = 1'b0;
    end
  endfunction

  function automatic void modelStep(input int k);
    bit          r[2];
    logic [15:0] d[2];
    int          o;
    int          other;
    r[0] = req0;
    r[1] = req1;
    d[0] = data0;
    d[1] = data1;
    o = mOwner[k];
    if (o >= 0 && r[o]) begin
      mData[k]  = d[o];
      mValid[k] = 1'b1;
    end else begin
      mValid[k] = 1'b0;
    end
    if (o < 0) begin
      mHeld[k] = 0;
      if (r[0] && r[1]) mOwner[k] = 1 - mLast[k];
      else if (r[0])    mOwner[k] = 0;
      else if (r[1])    mOwner[k] = 1;
    end else begin
      other = 1 - o;
      mHeld[k]++;
      if (!r[o]) begin
        mLast[k]  = o;
        mOwner[k] = r[other] ? other : -1;
        mHeld[k]  = 0;
      end else if (r[other] && mMax[k] != 0 && mHeld[k] >= mMax[k]) begin
        mLast[k]  = o;
        mOwner[k] = other;
        mHeld[k]  = 0;
      end
    end
  endfunction

  function automatic logic [31:0] expectedOf(input int k);
    return {11'b0, mOwner[k] == 0, mOwner[k] == 1, mOwner[k] == 1, mValid[k], mData[k]};
  endfunction

  function automatic logic [31:0] observedOf(input int k);
    if (k == 0)
      return {11'b0, bus8.Gnt0, bus8.Gnt1, bus8.Sel, bus8.OutValid, bus8.OutData};
    return {11'b0, bus0.Gnt0, bus0.Gnt1, bus0.Sel, bus0.OutValid, bus0.OutData};
  endfunction

  task automatic stepCycle(input bit randData);
    @(posedge CLK);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("dut8_outputs", observedOf(0), expectedOf(0));
    checkOutput("dut0_outputs", observedOf(1), expectedOf(1));
    gnt0Seen[0]  += int'(bus8.Gnt0);
    gnt0Seen[1]  += int'(bus0.Gnt0);
    validSeen[0] += int'(bus8.OutValid);
    validSeen[1] += int'(bus0.OutValid);
    if (randData) begin
      data0 = 16'($urandom);
      data1 = 16'($urandom);
    end
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input int cycles,
                               input bit randData);
    req0 = r0;
    req1 = r1;
    repeat (cycles) stepCycle(randData);
  endtask

  // Reset is asserted between clock edges, and outputs are checked before
  // any rising edge can occur.
  task automatic resetAsync();
    #3 Reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_dut8", observedOf(0), 32'h0);
    checkOutput("reset_dut0", observedOf(1), 32'h0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge CLK);
    #2 Reset_n = 1'b1;
  endtask

  initial begin
    mMax[0] = 8;
    mMax[1] = 0;
    modelReset();
    #7;
    resetAsync();

    data0 = 16'h1234;
    data1 = 16'h0000;
    applyStimulus(1'b1, 1'b0, 3, 1'b0);
    checkOutput("t1_outdata", {16'h0, bus8.OutData}, 32'h0000_1234);
    checkOutput("t1_sel", {31'b0, bus8.Sel}, 32'h0);

    resetAsync();
    applyStimulus(1'b1, 1'b1, 3, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, 1'b1);
    checkOutput("t2_handover", {30'b0, bus8.Gnt1, bus8.Sel}, 32'h3);
    applyStimulus(1'b0, 1'b1, 2, 1'b1);
    applyStimulus(1'b0, 1'b0, 2, 1'b1);
    applyStimulus(1'b1, 1'b1, 2, 1'b1);
    checkOutput("t2_rr_gnt0", {31'b0, bus8.Gnt0}, 32'h1);

    applyStimulus(1'b0, 1'b0, 2, 1'b1);
    resetAsync();
    gnt0Seen  = '{0, 0};
    validSeen = '{0, 0};
    applyStimulus(1'b1, 1'b1, 8, 1'b1);
    checkOutput("t3_hold8_len", gnt0Seen[0], 32'd8);
    applyStimulus(1'b1, 1'b1, 1, 1'b1);
    checkOutput("t3_preempt", {30'b0, bus8.Gnt0, bus8.Gnt1}, 32'h1);
    applyStimulus(1'b1, 1'b1, 41, 1'b1);
    checkOutput("t4_nolimit_gnt0", gnt0Seen[1], 32'd50);
    checkOutput("t4_nolimit_valid", validSeen[1], 32'd49);
    applyStimulus(1'b1, 1'b1, 7, 1'b1);
    applyStimulus(1'b1, 1'b0, 1, 1'b1);
    checkOutput("t3_regain", {30'b0, bus8.Gnt0, bus8.Gnt1}, 32'h2);

    applyStimulus(1'b0, 1'b1, 3, 1'b1);
    checkOutput("t5_pre_valid", {30'b0, bus8.Gnt1, bus8.OutValid}, 32'h3);
    resetAsync();
    applyStimulus(1'b1, 1'b1, 2, 1'b1);
    checkOutput("t5_tie_gnt0", {31'b0, bus8.Gnt0}, 32'h1);

    applyStimulus(1'b0, 1'b0, 2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, 1'b1);
    checkOutput("t6_pulse_gnt1", {31'b0, bus8.Gnt1}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1, 1'b1);
    checkOutput("t6_no_transfer", {30'b0, bus8.Gnt1, bus8.OutValid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1, 1'b1);
    checkOutput("t6_lastgnt", {31'b0, bus8.Gnt0}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) resetAsync();
      req0 = ($urandom_range(0, 9) < 7);
      req1 = ($urandom_range(0, 9) < 7);
      stepCycle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
